// File: rtl/udp_rx_pkg.sv
// udp_rx_pkg: protocol constants and FSM encoding shared by the UDP receive path.
package udp_rx_pkg;

    localparam logic [7:0]  UDP_PROTO   = 8'd17;
    localparam logic [15:0] UDP_HDR_LEN = 16'd8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_HDR,
        S_PAY,
        S_DROP
    } state_t;

endpackage

// File: rtl/udp_rx.sv
// udp_rx: strips the UDP header, filters on protocol/local port and trims padding from the payload stream.
module udp_rx
    import udp_rx_pkg::*;
#(
    parameter logic [15:0] P_LOCAL_UDP_PORT = 16'h8080
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [15:0] i_local_port,
    input  logic        i_local_valid,
    input  logic [7:0]  i_ip_type,
    input  logic [7:0]  i_ip_data,
    input  logic [15:0] i_ip_len,
    input  logic        i_ip_last,
    input  logic        i_ip_valid,
    output logic [15:0] o_udp_src_port,
    output logic [7:0]  o_udp_data,
    output logic [15:0] o_udp_len,
    output logic        o_udp_last,
    output logic        o_udp_valid,
    output logic        o_udp_err
);

    state_t      state, state_nx;
    logic        first;
    logic [2:0]  hdr_cnt, idx;
    logic [15:0] src, len, pay_cnt, local_port;
    logic [7:0]  dst_hi;
    logic        in_hdr, hdr_end, port_ok, pay_byte, pay_hit;
    logic        load_hdr, last_d, err_d;
    logic        ip_len_unused;

    assign ip_len_unused = ^i_ip_len;

    // A frame already in flight when reset releases is never parsed as a header.
    assign in_hdr   = i_ip_valid && (state == S_HDR || (state == S_IDLE && !first));
    assign idx      = state == S_HDR ? hdr_cnt : 3'd0;
    assign hdr_end  = in_hdr && idx == 3'd7;
    assign port_ok  = i_ip_type == UDP_PROTO && {dst_hi, i_ip_data} == local_port;
    assign pay_byte = i_ip_valid && state == S_PAY;
    assign pay_hit  = pay_cnt == o_udp_len - 16'd1;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (i_ip_valid)
            case (state)
                S_IDLE:  state_nx = i_ip_last ? S_IDLE : first ? S_DROP : S_HDR;
                S_HDR:   state_nx = i_ip_last ? S_IDLE :
                                    (idx == 3'd3 && !port_ok) ? S_DROP :
                                    idx == 3'd7 ? (len > UDP_HDR_LEN ? S_PAY : S_DROP) : S_HDR;
                S_PAY:   state_nx = i_ip_last ? S_IDLE : pay_hit ? S_DROP : S_PAY;
                S_DROP:  state_nx = i_ip_last ? S_IDLE : S_DROP;
                default: state_nx = S_IDLE;
            endcase
    end

    // A header ending exactly at the IP last byte is only legal for an empty datagram.
    always_comb begin
        load_hdr = hdr_end && !i_ip_last && len > UDP_HDR_LEN;
        last_d   = pay_byte && (pay_hit || i_ip_last);
        err_d    = (pay_byte && i_ip_last && !pay_hit) ||
                   (hdr_end && len < UDP_HDR_LEN) ||
                   (in_hdr && i_ip_last && !(hdr_end && len == UDP_HDR_LEN));
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            first          <= 1'b1;
            hdr_cnt        <= '0;
            src            <= '0;
            dst_hi         <= '0;
            len            <= '0;
            pay_cnt        <= '0;
            local_port     <= P_LOCAL_UDP_PORT;
            o_udp_src_port <= '0;
            o_udp_data     <= '0;
            o_udp_len      <= '0;
            o_udp_last     <= 1'b0;
            o_udp_valid    <= 1'b0;
            o_udp_err      <= 1'b0;
        end else begin
            first       <= 1'b0;
            o_udp_valid <= pay_byte;
            o_udp_last  <= last_d;
            o_udp_err   <= err_d;
            if (i_local_valid) local_port <= i_local_port;
            if (pay_byte) begin
                o_udp_data <= i_ip_data;
                pay_cnt    <= pay_cnt + 16'd1;
            end
            if (in_hdr) begin
                hdr_cnt <= idx + 3'd1;
                case (idx)
                    3'd0:    src[15:8] <= i_ip_data;
                    3'd1:    src[7:0]  <= i_ip_data;
                    3'd2:    dst_hi    <= i_ip_data;
                    3'd4:    len[15:8] <= i_ip_data;
                    3'd5:    len[7:0]  <= i_ip_data;
                    default: ;
                endcase
            end
            if (load_hdr) begin
                o_udp_len      <= len - UDP_HDR_LEN;
                o_udp_src_port <= src;
                pay_cnt        <= '0;
            end
        end
    end

endmodule

// File: tb/tb_udp_rx.sv
// tb_udp_rx: directed frames with a scoreboard of expected payload bytes and error pulses.
module tb_udp_rx;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [15:0] i_local_port = '0;
    logic        i_local_valid = 1'b0;
    logic [7:0]  i_ip_type = '0;
    logic [7:0]  i_ip_data = '0;
    logic [15:0] i_ip_len = '0;
    logic        i_ip_last = 1'b0;
    logic        i_ip_valid = 1'b0;
    logic [15:0] o_udp_src_port;
    logic [7:0]  o_udp_data;
    logic [15:0] o_udp_len;
    logic        o_udp_last;
    logic        o_udp_valid;
    logic        o_udp_err;

    typedef struct packed {
        logic [7:0]  data;
        logic        last;
        logic        err;
        logic        valid;
        logic [15:0] len;
        logic [15:0] src;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          failures = 0;
    logic [15:0] exp_port = 16'h8080;
    bit          gap_en = 1'b0;

    udp_rx dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_local_port(i_local_port), .i_local_valid(i_local_valid),
        .i_ip_type(i_ip_type), .i_ip_data(i_ip_data), .i_ip_len(i_ip_len),
        .i_ip_last(i_ip_last), .i_ip_valid(i_ip_valid),
        .o_udp_src_port(o_udp_src_port), .o_udp_data(o_udp_data), .o_udp_len(o_udp_len),
        .o_udp_last(o_udp_last), .o_udp_valid(o_udp_valid), .o_udp_err(o_udp_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    always @(negedge i_clk) begin
        exp_t e;
        if (!i_rst && (o_udp_valid || o_udp_err)) begin
            checks++;
            assert (q.size() > 0) else begin
                failures++;
                $error("FAIL unexpected_out observed valid=%0b err=%0b data=%h expected no output",
                       o_udp_valid, o_udp_err, o_udp_data);
            end
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("valid", 16'(o_udp_valid), 16'(e.valid));
                chk("err", 16'(o_udp_err), 16'(e.err));
                chk("last", 16'(o_udp_last), 16'(e.last));
                if (e.valid) begin
                    chk("data", 16'(o_udp_data), 16'(e.data));
                    chk("len", o_udp_len, e.len);
                    chk("src", o_udp_src_port, e.src);
                end
            end
        end
    end

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle(input int n);
        i_ip_valid = 1'b0;
        i_ip_last  = 1'b0;
        repeat (n) step();
    endtask

    task automatic set_port(input logic [15:0] p);
        i_local_port  = p;
        i_local_valid = 1'b1;
        step();
        i_local_valid = 1'b0;
        exp_port      = p;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid"}, 16'(o_udp_valid), 16'd0);
        chk({tag, "_last"}, 16'(o_udp_last), 16'd0);
        chk({tag, "_err"}, 16'(o_udp_err), 16'd0);
        chk({tag, "_data"}, 16'(o_udp_data), 16'd0);
        chk({tag, "_len"}, o_udp_len, 16'd0);
        chk({tag, "_src"}, o_udp_src_port, 16'd0);
    endtask

    // total counts IP payload bytes including the header; rst_at<0 disables the mid-frame reset.
    task automatic send(input logic [15:0] src, input logic [15:0] dst, input logic [7:0] typ,
                        input logic [15:0] ulen, input int total, input logic [7:0] seed,
                        input int rst_at);
        logic [7:0] b;
        exp_t       e;
        bit         acc;
        int         plen, avail, n;
        acc   = typ == 8'd17 && dst == exp_port;
        plen  = int'(ulen) - 8;
        avail = total - 8;
        n     = plen < avail ? plen : avail;
        for (int i = 0; i < total; i++) begin
            if (i == rst_at) begin
                i_ip_valid = 1'b0;
                step();
                i_rst = 1'b1;
                #1;
                check_zero("rst_mid");
                acc      = 1'b0;
                exp_port = 16'h8080;
            end
            if (rst_at >= 0 && i == rst_at + 2) i_rst = 1'b0;
            case (i)
                0:       b = src[15:8];
                1:       b = src[7:0];
                2:       b = dst[15:8];
                3:       b = dst[7:0];
                4:       b = ulen[15:8];
                5:       b = ulen[7:0];
                6, 7:    b = 8'h00;
                default: b = seed + 8'(i - 8);
            endcase
            i_ip_type  = typ;
            i_ip_len   = 16'(total);
            i_ip_data  = b;
            i_ip_valid = 1'b1;
            i_ip_last  = i == total - 1;
            if (acc && i == 7 && ulen < 16'd8) begin
                e = '0;
                e.err = 1'b1;
                q.push_back(e);
            end
            if (acc && i >= 8 && i - 8 < n) begin
                e.data  = b;
                e.last  = i - 8 == n - 1;
                e.err   = (i - 8 == n - 1) && avail < plen;
                e.valid = 1'b1;
                e.len   = ulen - 16'd8;
                e.src   = src;
                q.push_back(e);
            end
            step();
            if (gap_en && (i % 5) == 2) begin
                i_ip_valid = 1'b0;
                step();
            end
        end
    endtask

    initial begin
        repeat (3) @(posedge i_clk);
        #1;
        check_zero("reset");
        i_rst = 1'b0;
        idle(3);
        // clean 30-byte payload, then a padded 4-byte payload
        send(16'hA001, 16'h8080, 8'd17, 16'h0026, 38, 8'h10, -1);
        idle(2);
        send(16'hA002, 16'h8080, 8'd17, 16'h000C, 26, 8'h40, -1);
        // filtered frames back-to-back with a good one
        send(16'hA003, 16'h1234, 8'd17, 16'h0010, 24, 8'h50, -1);
        send(16'hA004, 16'h8080, 8'd6, 16'h0010, 24, 8'h60, -1);
        send(16'hA005, 16'h8080, 8'd17, 16'h0010, 24, 8'h70, -1);
        idle(2);
        // truncated payload, then a short length field
        send(16'hA006, 16'h8080, 8'd17, 16'h0030, 18, 8'h80, -1);
        send(16'hA007, 16'h8080, 8'd17, 16'h0005, 20, 8'h90, -1);
        send(16'hA008, 16'h8080, 8'd17, 16'h0008, 12, 8'h99, -1);
        idle(2);
        set_port(16'h1234);
        gap_en = 1'b1;
        send(16'hB001, 16'h1234, 8'd17, 16'h0014, 28, 8'hA0, -1);
        send(16'hB002, 16'h8080, 8'd17, 16'h0014, 28, 8'hB0, -1);
        send(16'hB003, 16'h1234, 8'd17, 16'h000B, 30, 8'hC0, -1);
        gap_en = 1'b0;
        idle(2);
        set_port(16'h8080);
        send(16'hC001, 16'h8080, 8'd17, 16'h0026, 38, 8'hD0, 14);
        send(16'hC002, 16'h8080, 8'd17, 16'h000E, 22, 8'hE0, -1);
        idle(5);
        chk("queue_empty", 16'(q.size()), 16'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
